// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/bubble/flush sequencer.
// FSM encodings, state width and default multi-cycle timeout.
package pipeline_stall_controller_pkg;

    localparam int STATE_W        = 2;
    localparam int MC_TIMEOUT_DEF = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_MC_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_stall_controller_perf_counter.sv
// Saturating event counter used for the optional stall statistics.
// Counts one per enabled cycle and holds at all-ones.
module stall_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/bubble/flush sequencer for the 5-stage core.
// Optional performance counters are enabled with the STALL_PERF_CNT_EN macro.
//
//   state      | meaning
//   ST_RUN     | no multi-cycle op outstanding
//   ST_MC_BUSY | multi-cycle op in flight, EX frozen until done
//   ST_MC_HOLD | result ready but MEM still waiting, unit keeps result
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_use_hazard,
    input  logic               ex_mc_start,
    input  logic               ex_mc_done,
    input  logic               mem_req,
    input  logic               mem_ready,
    input  logic               branch_taken,
    input  logic               trap_flush,
    output logic               stall_pc,
    output logic               stall_ifid,
    output logic               stall_idex,
    output logic               stall_exmem,
    output logic               bubble_idex,
    output logic               bubble_exmem,
    output logic               bubble_memwb,
    output logic               flush_ifid,
    output logic               flush_idex,
    output logic               mc_hold,
    output logic               mc_abort,
    output logic               mc_timeout,
    output logic [STATE_W-1:0] ctrl_state
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   perf_mem_stall_cnt,
    output logic [CNT_W-1:0]   perf_mc_stall_cnt,
    output logic [CNT_W-1:0]   perf_ld_use_cnt
`endif
);

    localparam int TW = $clog2(MC_TIMEOUT + 1);

    if (MC_TIMEOUT < 2 || CNT_W < 1) begin : g_param_check
        $error("pipeline_stall_controller: MC_TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mc_timeout_q, mc_timeout_d;
    logic          mem_stall, mc_stall, busy_stay;

    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        state_d      = state_q;
        mc_stall     = 1'b0;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        bubble_memwb = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        mc_abort     = 1'b0;

        case (state_q)
            ST_RUN: begin
                mc_stall = ex_mc_start && !ex_mc_done;
                if (mc_stall) state_d = ST_MC_BUSY;
            end
            ST_MC_BUSY: begin
                mc_stall = !ex_mc_done;
                if (ex_mc_done) state_d = mem_stall ? ST_MC_HOLD : ST_RUN;
            end
            ST_MC_HOLD: begin
                mc_stall = mem_stall;
                if (!mem_stall) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Redirect sources are ranked so a frozen stage never loses its instruction
        if (trap_flush) begin
            state_d      = ST_RUN;
            flush_ifid   = 1'b1;
            flush_idex   = 1'b1;
            bubble_exmem = 1'b1;
            mc_abort     = (state_q != ST_RUN) || ex_mc_start;
        end else if (mem_stall) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            stall_exmem  = 1'b1;
            bubble_memwb = 1'b1;
        end else if (mc_stall) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
        end else if (branch_taken) begin
            flush_ifid   = 1'b1;
            flush_idex   = 1'b1;
        end else if (ld_use_hazard) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            bubble_idex  = 1'b1;
        end
    end

    assign mc_hold = ((state_q == ST_MC_BUSY) && ex_mc_done && mem_stall)
                   || (state_q == ST_MC_HOLD);

    assign busy_stay = (state_q == ST_MC_BUSY) && !ex_mc_done && !trap_flush;

    always_comb begin
        tmo_cnt_d = '0;
        if (busy_stay) begin
            tmo_cnt_d = (tmo_cnt_q == TW'(MC_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
        end
        mc_timeout_d = mc_timeout_q || (tmo_cnt_d == TW'(MC_TIMEOUT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            tmo_cnt_q    <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mc_timeout_q <= mc_timeout_d;
        end
    end

    assign mc_timeout = mc_timeout_q;
    assign ctrl_state = state_q;

`ifdef STALL_PERF_CNT_EN
    stall_perf_counter #(.W(CNT_W)) u_mem_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (mem_stall),
        .cnt_o (perf_mem_stall_cnt)
    );

    stall_perf_counter #(.W(CNT_W)) u_mc_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (mc_stall && !mem_stall),
        .cnt_o (perf_mc_stall_cnt)
    );

    stall_perf_counter #(.W(CNT_W)) u_ld_use_cnt (
        .clk   (clk),
        .reset (reset),
        .en_i  (bubble_idex),
        .cnt_o (perf_ld_use_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed table, corner
// sequences and a randomized run against a behavioural model.
module tb_pipeline_stall_controller;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ld_use_hazard = 0, ex_mc_start = 0, ex_mc_done = 0;
    logic mem_req = 0, mem_ready = 0, branch_taken = 0, trap_flush = 0;
    logic stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic bubble_idex, bubble_exmem, bubble_memwb, flush_ifid, flush_idex;
    logic mc_hold, mc_abort, mc_timeout;
    logic [1:0] ctrl_state;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_mem_stall_cnt, perf_mc_stall_cnt, perf_ld_use_cnt;
`endif

    logic       pc_en = 1'b0;
    logic [2:0] pc_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MC_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ld_use_hazard(ld_use_hazard), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .trap_flush(trap_flush),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem),
        .bubble_memwb(bubble_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mc_hold(mc_hold), .mc_abort(mc_abort), .mc_timeout(mc_timeout),
        .ctrl_state(ctrl_state)
`ifdef STALL_PERF_CNT_EN
        , .perf_mem_stall_cnt(perf_mem_stall_cnt), .perf_mc_stall_cnt(perf_mc_stall_cnt),
        .perf_ld_use_cnt(perf_ld_use_cnt)
`endif
    );

    stall_perf_counter #(.W(3)) u_pc (.clk(clk), .reset(reset), .en_i(pc_en), .cnt_o(pc_cnt));

    wire [13:0] outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, bubble_idex,
                        bubble_exmem, bubble_memwb, flush_ifid, flush_idex,
                        mc_hold, mc_abort, mc_timeout, ctrl_state};

    // Behavioural model: op in flight / result parked / busy cycle count
    bit m_busy, m_held, m_tmo;
    int m_cnt;

    function automatic logic [13:0] model_out(logic [6:0] v);
        logic ld, st, dn, ms, br, tr, in_run, mcs, hold, abort;
        logic [6:0] sb;
        logic [1:0] fl, s;
        ld = v[6]; st = v[5]; dn = v[4]; br = v[1]; tr = v[0];
        ms = v[3] && !v[2];
        in_run = !m_busy && !m_held;
        mcs = (in_run && st && !dn) || (m_busy && !dn) || (m_held && ms);
        sb = 7'b0; fl = 2'b0; abort = 1'b0;
        if (tr) begin
            fl = 2'b11; sb = 7'b0000010; abort = !in_run || st;
        end else if (ms) sb = 7'b1111001;
        else if (mcs) sb = 7'b1110010;
        else if (br) fl = 2'b11;
        else if (ld) sb = 7'b1100100;
        hold = (m_busy && dn && ms) || m_held;
        s = m_busy ? 2'd1 : (m_held ? 2'd2 : 2'd0);
        return {sb, fl, hold, abort, m_tmo, s};
    endfunction

    task automatic model_step(logic [6:0] v);
        logic ms;
        ms = v[3] && !v[2];
        if (v[0]) begin
            m_busy = 0; m_held = 0; m_cnt = 0;
        end else if (!m_busy && !m_held) begin
            m_busy = v[5] && !v[4]; m_cnt = 0;
        end else if (m_busy) begin
            if (v[4]) begin
                m_busy = 0; m_held = ms; m_cnt = 0;
            end else begin
                if (m_cnt < TMO) m_cnt++;
                if (m_cnt >= TMO) m_tmo = 1;
            end
        end else begin
            m_held = ms;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_held = 0; m_tmo = 0; m_cnt = 0;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(logic [6:0] v);
        {ld_use_hazard, ex_mc_start, ex_mc_done, mem_req, mem_ready, branch_taken, trap_flush} = v;
    endtask

    task automatic drive(logic [6:0] v);
        apply(v);
        #4;
    endtask

    task automatic tick(logic [6:0] v);
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(string name, logic [6:0] v);
        drive(v);
        chk(name, 32'(outs), 32'(model_out(v)));
        tick(v);
    endtask

    task automatic do_reset();
        apply(7'b0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("reset_state", 32'(outs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [6:0] in;
        logic [13:0] exp;
    } vec_t;

    localparam logic [6:0] V_LD = 7'b1000000, V_ST = 7'b0100000, V_DN = 7'b0010000;
    localparam logic [6:0] V_RQ = 7'b0001000, V_RDY = 7'b0000100, V_BR = 7'b0000010;
    localparam logic [6:0] V_TR = 7'b0000001;

    vec_t tab[14];

    initial begin
        int n;
        logic [6:0] v;

        tab[0]  = '{"idle",          7'b0,               {7'b0000000, 2'b00, 3'b000, 2'd0}};
        tab[1]  = '{"ld_use",        V_LD,               {7'b1100100, 2'b00, 3'b000, 2'd0}};
        tab[2]  = '{"br_over_ld",    V_LD|V_BR,          {7'b0000000, 2'b11, 3'b000, 2'd0}};
        tab[3]  = '{"mem_over_br",   V_LD|V_BR|V_RQ,     {7'b1111001, 2'b00, 3'b000, 2'd0}};
        tab[4]  = '{"mem_ready_ld",  V_LD|V_RQ|V_RDY,    {7'b1100100, 2'b00, 3'b000, 2'd0}};
        tab[5]  = '{"trap_run",      V_TR,               {7'b0000010, 2'b11, 3'b000, 2'd0}};
        tab[6]  = '{"trap_start",    V_ST|V_TR,          {7'b0000010, 2'b11, 3'b010, 2'd0}};
        tab[7]  = '{"single_cycle",  V_ST|V_DN,          {7'b0000000, 2'b00, 3'b000, 2'd0}};
        tab[8]  = '{"mc_start",      V_LD|V_ST|V_BR,     {7'b1110010, 2'b00, 3'b000, 2'd0}};
        tab[9]  = '{"mc_busy",       V_ST,               {7'b1110010, 2'b00, 3'b000, 2'd1}};
        tab[10] = '{"done_mem_wait", V_ST|V_DN|V_RQ,     {7'b1111001, 2'b00, 3'b100, 2'd1}};
        tab[11] = '{"hold_mem_wait", V_RQ,               {7'b1111001, 2'b00, 3'b100, 2'd2}};
        tab[12] = '{"hold_release",  7'b0,               {7'b0000000, 2'b00, 3'b100, 2'd2}};
        tab[13] = '{"back_to_run",   7'b0,               {7'b0000000, 2'b00, 3'b000, 2'd0}};

        model_reset();
        #1;
        chk("reset_state", 32'(outs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(tab[i].in);
            chk(tab[i].name, 32'(outs), 32'(tab[i].exp));
            tick(tab[i].in);
        end

        // saturating counter unit
        pc_en = 1'b1;
        for (int i = 0; i < 5; i++) run_vec("pc_idle", 7'b0);
        pc_en = 1'b0;
        #1;
        chk("pc_count5", 32'(pc_cnt), 32'd5);
        pc_en = 1'b1;
        for (int i = 0; i < 5; i++) run_vec("pc_idle", 7'b0);
        pc_en = 1'b0;
        #1;
        chk("pc_saturate", 32'(pc_cnt), 32'd7);
        do_reset();
        chk("pc_reset", 32'(pc_cnt), 32'd0);

        // 33-cycle divide
        n = 0;
        for (int i = 0; i < 34; i++) begin
            v = (i == 33) ? (V_ST | V_DN) : V_ST;
            drive(v);
            if (stall_pc) n++;
            if (i == 1)  chk("div_state_busy", 32'(ctrl_state), 32'd1);
            if (i == 33) chk("div_done_nostall", 32'(stall_pc), 32'd0);
            chk("div_model", 32'(outs), 32'(model_out(v)));
            tick(v);
        end
        chk("div_stall_cycles", 32'(n), 32'd33);
        drive(7'b0);
        chk("div_state_run", 32'(ctrl_state), 32'd0);
        tick(7'b0);

        // timeout then trap abort
        do_reset();
        run_vec("tmo_enter", V_ST);
        for (int k = 1; k <= TMO; k++) begin
            drive(V_ST);
            chk("tmo_early", 32'(mc_timeout), 32'd0);
            tick(V_ST);
        end
        drive(V_ST);
        chk("tmo_set", 32'(mc_timeout), 32'd1);
        tick(V_ST);
        drive(V_ST | V_TR);
        chk("trap_abort", 32'({mc_abort, flush_ifid, flush_idex, stall_pc}), 32'b1110);
        tick(V_ST | V_TR);
        drive(7'b0);
        chk("tmo_sticky", 32'({mc_timeout, ctrl_state}), 32'b100);
        tick(7'b0);

        // async reset in MC_BUSY
        run_vec("ar_enter", V_ST);
        drive(V_ST);
        chk("ar_busy", 32'(ctrl_state), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset", 32'({ctrl_state, mc_timeout}), 32'd0);
        apply(7'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef STALL_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 5; i++) run_vec("perf_mem", V_RQ);
        for (int i = 0; i < 2; i++) run_vec("perf_ld", V_LD);
        run_vec("perf_mc", V_ST);
        chk("perf_mem_cnt", perf_mem_stall_cnt, 32'd5);
        chk("perf_ld_cnt", perf_ld_use_cnt, 32'd2);
        chk("perf_mc_cnt", perf_mc_stall_cnt, 32'd1);
        reset = 1'b1;
        #1;
        chk("perf_reset", perf_mem_stall_cnt | perf_ld_use_cnt | perf_mc_stall_cnt, 32'd0);
        apply(7'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                v[6] = ($urandom_range(0, 3) == 0);
                v[5] = ($urandom_range(0, 1) == 0);
                v[4] = ($urandom_range(0, 4) == 0);
                v[3] = ($urandom_range(0, 1) == 0);
                v[2] = ($urandom_range(0, 1) == 0);
                v[1] = ($urandom_range(0, 3) == 0);
                v[0] = ($urandom_range(0, 15) == 0);
                run_vec("random", v);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall, bubble and flush sequencer for the 5-stage RV core. It merges four inputs into one consistent set of per-stage hold and bubble controls:
- load-use hazard indication from ID
- busy/done handshake of the multi-cycle M-extension unit in EX
- data-memory wait states in MEM
- branch and trap redirects

It sits beside the pipeline registers and replaces the ad hoc OR-ing of stall sources in the core top.

Parameters:
MC_TIMEOUT, 64, max cycles a multi-cycle op may stay busy before mc_timeout is flagged (must be ≥2)
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
ld_use_hazard  in  1  load-use hazard detected for the instruction in ID
ex_mc_start  in  1  valid multi-cycle op (MUL/DIV) present in EX
ex_mc_done  in  1  multi-cycle unit result valid this cycle
mem_req  in  1  valid load/store in MEM
mem_ready  in  1  data memory completes the access this cycle
branch_taken  in  1  EX resolved a taken branch/jump (redirect)
trap_flush  in  1  trap/exception/mret redirect from MEM/WB
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
stall_idex  out  1  hold ID/EX
stall_exmem  out  1  hold EX/MEM
bubble_idex  out  1  load NOP into ID/EX
bubble_exmem  out  1  load NOP into EX/MEM
bubble_memwb  out  1  load NOP into MEM/WB
flush_ifid  out  1  squash IF/ID
flush_idex  out  1  squash ID/EX
mc_hold  out  1  multi-cycle unit must retain its result
mc_abort  out  1  cancel in-flight multi-cycle op
mc_timeout  out  1  sticky error: MC_TIMEOUT exceeded
ctrl_state  out  2  FSM state (debug)

Behaviour:
- Reset (async): FSM=RUN, timeout counter=0, mc_timeout=0. All outputs except ctrl_state are combinational from state and inputs; with inputs low they are all 0.
- FSM states: RUN=0, MC_BUSY=1, MC_HOLD=2.
- Internal signals:
  - mem_stall = mem_req && !mem_ready
  - mc_stall = (RUN && ex_mc_start && !ex_mc_done) || (MC_BUSY && !ex_mc_done) || (MC_HOLD && mem_stall)
- Transitions:
  - RUN→MC_BUSY on ex_mc_start && !ex_mc_done && !trap_flush
  - MC_BUSY→RUN on ex_mc_done && !mem_stall
  - MC_BUSY→MC_HOLD on ex_mc_done && mem_stall
  - MC_HOLD→RUN when !mem_stall
  - A single-cycle completion (start && done in RUN) stays in RUN with no stall.
- mc_hold = (MC_BUSY && ex_mc_done && mem_stall) || MC_HOLD.
- Priority, highest first:
  1. trap_flush:
     - flush_ifid=flush_idex=1, bubble_exmem=1
     - all stalls 0, bubble_idex=0
     - mc_abort=1 if state≠RUN or ex_mc_start
     - FSM→RUN next cycle, counter cleared
  2. mem_stall: stall_pc, stall_ifid, stall_idex and stall_exmem=1; bubble_memwb=1. No flush or load-use bubble; branch_taken is ignored this cycle because the branch stays frozen in EX and is re-presented.
  3. mc_stall: stall_pc, stall_ifid and stall_idex=1; bubble_exmem=1. branch_taken and ld_use_hazard are ignored.
  4. branch_taken: flush_ifid=flush_idex=1. ld_use_hazard is ignored because ID holds a wrong-path instruction.
  5. ld_use_hazard: stall_pc=stall_ifid=1, bubble_idex=1 (exactly one cycle per assertion).
- Timeout counter:
  - increments each cycle in MC_BUSY, saturating
  - clears on leaving MC_BUSY or on trap
  - reaching MC_TIMEOUT sets mc_timeout, which stays set until reset
- Reset mid-operation: FSM and counter clear immediately; the pipeline is assumed flushed by the same reset.

Optional Feature:
STALL_PERF_CNT_EN:
- When defined, adds three saturating CNT_W-bit outputs:
  - perf_mem_stall_cnt: cycles with mem_stall
  - perf_mc_stall_cnt: cycles with mc_stall && !mem_stall
  - perf_ld_use_cnt: load-use bubbles actually inserted
- Counters reset asynchronously to 0 and saturate at all-ones.
- When undefined, the ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Shared core package holds:
  - FSM state encodings ST_RUN/ST_MC_BUSY/ST_MC_HOLD
  - the 2-bit state width constant
  - the MC_TIMEOUT default
- One natural sub-module: stall_perf_counter (saturating counter with enable), instantiated three times under the macro.
- Priority-encoded output logic stays in the top module.

Test Plan:
- Load-use only: ld_use_hazard=1 for 1 cycle in RUN → stall_pc=stall_ifid=bubble_idex=1 that cycle only; ctrl_state stays 0.
- DIV: ex_mc_start=1, ex_mc_done pulses 33 cycles later → stall_pc/ifid/idex=1 and bubble_exmem=1 for 33 cycles; state 0→1→0; no stall in the done cycle.
- Done during mem wait: in MC_BUSY, ex_mc_done=1 while mem_req=1, mem_ready=0 for 3 cycles:
  - state goes to 2 with mc_hold=1 and all four stalls=1
  - state returns to 0 the cycle mem_ready=1
- Branch vs load-use: branch_taken=1 and ld_use_hazard=1 together → flush_ifid=flush_idex=1, stall_pc=0, bubble_idex=0. With mem_stall also high → no flush that cycle.
- Trap abort: trap_flush=1 in MC_BUSY → mc_abort=1, flushes asserted, state=0 next cycle. MC_TIMEOUT=4 with done never arriving → mc_timeout=1 after 4 busy cycles and sticky.
- With STALL_PERF_CNT_EN: 5 mem-wait cycles and 2 load-use bubbles → perf_mem_stall_cnt=5, perf_ld_use_cnt=2. Reset asserted mid-run → all counters 0 asynchronously.
